// File: rtl/conv_layer_scheduler.sv
// Convolution layer scheduler: sequences preload/shift/load commands to the
// input interface and emits tagged valid strobes for each finished shift.
module conv_layer_scheduler #(
  parameter int KERNEL_SIZE   = 3,
  parameter int ARRAY_SIZE    = 6,
  parameter int ARRAY_WIDTH   = 3,
  parameter int TOTAL_WEIGHT  = 4,
  parameter int WEIGHT_WIDTH  = 2,
  parameter int NUM_CHANNEL   = 2,
  parameter int CHANNEL_WIDTH = 1,
  parameter int VALID_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     continuous,
  input  logic                     stall,
  input  logic [1:0]               input_interface_ack,
  output logic [1:0]               input_interface_cmd,
  output logic                     busy,
  output logic                     valid,
  output logic [WEIGHT_WIDTH-1:0]  feature_idx,
  output logic [CHANNEL_WIDTH-1:0] feature_channel,
  output logic [ARRAY_WIDTH-1:0]   feature_row,
  output logic                     image_calc_fin
);

  localparam logic [1:0] ACK_LOAD_FIN  = 2'd1;
  localparam logic [1:0] ACK_SHIFT_FIN = 2'd2;
  localparam logic [1:0] CMD_IDLE      = 2'd0;
  localparam logic [1:0] CMD_LOAD      = 2'd1;
  localparam logic [1:0] CMD_SHIFT     = 2'd2;

  localparam int PRE_W = $clog2(KERNEL_SIZE + 1);
  localparam int TAG_W = ARRAY_WIDTH + CHANNEL_WIDTH + WEIGHT_WIDTH;
  localparam logic [TAG_W-1:0] LAST_TAG = {ARRAY_WIDTH'(ARRAY_SIZE - 1),
                                           CHANNEL_WIDTH'(NUM_CHANNEL - 1),
                                           WEIGHT_WIDTH'(TOTAL_WEIGHT - 1)};

  typedef enum logic [2:0] {IDLE, PRELOAD, SHIFT, LOAD, DONE} state_t;

  state_t                    state;
  logic [PRE_W-1:0]          pre_cnt;
  logic [WEIGHT_WIDTH-1:0]   w_cnt;
  logic [CHANNEL_WIDTH-1:0]  ch_cnt;
  logic [ARRAY_WIDTH-1:0]    row_cnt;
  logic                      due;
  logic                      outstanding;
  logic [VALID_LATENCY-1:0]  v_pipe;
  logic [VALID_LATENCY-1:0][TAG_W-1:0] t_pipe;

  logic last_pre, last_w, last_ch, last_row, ack_ok, cap_v;
  logic [TAG_W-1:0] cap_tag;

  always_comb begin
    last_pre = (pre_cnt == PRE_W'(KERNEL_SIZE - 1));
    last_w   = (w_cnt   == WEIGHT_WIDTH'(TOTAL_WEIGHT - 1));
    last_ch  = (ch_cnt  == CHANNEL_WIDTH'(NUM_CHANNEL - 1));
    last_row = (row_cnt == ARRAY_WIDTH'(ARRAY_SIZE - 1));
    // Only an ack matching the single outstanding command is honoured.
    ack_ok   = outstanding &&
               (((state == SHIFT) && (input_interface_ack == ACK_SHIFT_FIN)) ||
                (((state == PRELOAD) || (state == LOAD)) &&
                 (input_interface_ack == ACK_LOAD_FIN)));
    cap_v    = ack_ok && (state == SHIFT);
    cap_tag  = {row_cnt, ch_cnt, w_cnt};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      pre_cnt             <= '0;
      w_cnt               <= '0;
      ch_cnt              <= '0;
      row_cnt             <= '0;
      due                 <= 1'b0;
      outstanding         <= 1'b0;
      input_interface_cmd <= CMD_IDLE;
      v_pipe              <= '0;
      t_pipe              <= '0;
    end else if (!enable) begin
      state               <= IDLE;
      pre_cnt             <= '0;
      w_cnt               <= '0;
      ch_cnt              <= '0;
      row_cnt             <= '0;
      due                 <= 1'b0;
      outstanding         <= 1'b0;
      input_interface_cmd <= CMD_IDLE;
      v_pipe              <= '0;
    end else begin
      input_interface_cmd <= CMD_IDLE;

      v_pipe[0] <= cap_v;
      if (cap_v) t_pipe[0] <= cap_tag;
      for (int unsigned i = 1; i < VALID_LATENCY; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        if (v_pipe[i-1]) t_pipe[i] <= t_pipe[i-1];
      end

      // A due command waits out stall; due implies nothing is outstanding.
      if (due && !stall) begin
        input_interface_cmd <= (state == SHIFT) ? CMD_SHIFT : CMD_LOAD;
        due                 <= 1'b0;
        outstanding         <= 1'b1;
      end

      case (state)
        IDLE: begin
          state <= PRELOAD;
          due   <= 1'b1;
        end
        PRELOAD: if (ack_ok) begin
          outstanding <= 1'b0;
          due         <= 1'b1;
          if (last_pre) begin
            pre_cnt <= '0;
            state   <= SHIFT;
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
          end
        end
        LOAD: if (ack_ok) begin
          outstanding <= 1'b0;
          due         <= 1'b1;
          state       <= SHIFT;
        end
        SHIFT: if (ack_ok) begin
          outstanding <= 1'b0;
          due         <= !(last_w && last_ch && last_row) || continuous;
          if (!last_w) begin
            w_cnt <= w_cnt + 1'b1;
          end else begin
            w_cnt <= '0;
            if (!last_ch) begin
              ch_cnt <= ch_cnt + 1'b1;
            end else begin
              ch_cnt <= '0;
              if (!last_row) begin
                row_cnt <= row_cnt + 1'b1;
                state   <= LOAD;
              end else begin
                row_cnt <= '0;
                state   <= continuous ? PRELOAD : DONE;
              end
            end
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == PRELOAD) || (state == SHIFT) || (state == LOAD);
  assign valid = v_pipe[VALID_LATENCY-1];
  assign {feature_row, feature_channel, feature_idx} = t_pipe[VALID_LATENCY-1];
  assign image_calc_fin = valid && (t_pipe[VALID_LATENCY-1] == LAST_TAG);

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler with a small geometry (K=2, 3 rows,
// 2 weights, 2 channels, latency 2) and an interface responder acking 1 cycle late.
module tb_conv_layer_scheduler;

  localparam int K  = 2;
  localparam int AS = 3;
  localparam int TW = 2;
  localparam int NC = 2;
  localparam int VL = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       continuous;
  logic       stall;
  logic [1:0] input_interface_ack;
  logic [1:0] input_interface_cmd;
  logic       busy;
  logic       valid;
  logic [0:0] feature_idx;
  logic [0:0] feature_channel;
  logic [1:0] feature_row;
  logic       image_calc_fin;

  conv_layer_scheduler #(
    .KERNEL_SIZE  (K),
    .ARRAY_SIZE   (AS),
    .ARRAY_WIDTH  (2),
    .TOTAL_WEIGHT (TW),
    .WEIGHT_WIDTH (1),
    .NUM_CHANNEL  (NC),
    .CHANNEL_WIDTH(1),
    .VALID_LATENCY(VL)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .continuous         (continuous),
    .stall              (stall),
    .input_interface_ack(input_interface_ack),
    .input_interface_cmd(input_interface_cmd),
    .busy               (busy),
    .valid              (valid),
    .feature_idx        (feature_idx),
    .feature_channel    (feature_channel),
    .feature_row        (feature_row),
    .image_calc_fin     (image_calc_fin)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int nload, nshift, vcount, fincount, loads_before_shift, first_shift, first_v;
  int ex_row, ex_ch, ex_w;
  int fin_row, fin_ch, fin_w;
  int saved;
  logic [1:0] pending = 2'd0;
  logic       auto_ack = 1'b1;

  task automatic check(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    nload = 0; nshift = 0; vcount = 0; fincount = 0;
    loads_before_shift = -1; first_shift = -1; first_v = -1;
    ex_row = 0; ex_ch = 0; ex_w = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      vcount++;
      if (first_v < 0) first_v = cyc;
      check("tag_row", int'(feature_row), ex_row);
      check("tag_ch",  int'(feature_channel), ex_ch);
      check("tag_w",   int'(feature_idx), ex_w);
      check("fin_flag", int'(image_calc_fin),
            (ex_row == AS-1 && ex_ch == NC-1 && ex_w == TW-1) ? 1 : 0);
      if (image_calc_fin) begin
        fincount++;
        fin_row = feature_row; fin_ch = feature_channel; fin_w = feature_idx;
      end
      if (ex_w < TW-1) ex_w++;
      else begin
        ex_w = 0;
        if (ex_ch < NC-1) ex_ch++;
        else begin
          ex_ch = 0;
          ex_row = (ex_row < AS-1) ? ex_row + 1 : 0;
        end
      end
    end
    if (input_interface_cmd == 2'd1) nload++;
    if (input_interface_cmd == 2'd2) begin
      if (nshift == 0) begin
        loads_before_shift = nload;
        first_shift = cyc;
      end
      nshift++;
    end
    if (auto_ack) begin
      input_interface_ack = pending;
      pending = (input_interface_cmd == 2'd1) ? 2'd1 :
                (input_interface_cmd == 2'd2) ? 2'd2 : 2'd0;
    end
  endtask

  task automatic disable_run();
    enable = 1'b0;
    pending = 2'd0;
    input_interface_ack = 2'd0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; continuous = 1'b0; stall = 1'b0;
    input_interface_ack = 2'd0;
    clear_stats();
    repeat (3) step();
    check("rst_cmd",   int'(input_interface_cmd), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_tags",  int'({feature_row, feature_channel, feature_idx}), 0);
    check("rst_fin",   int'(image_calc_fin), 0);
    rst_n = 1'b1;
    step();

    // Full single image, stop in DONE
    enable = 1'b1;
    for (int i = 0; i < 300 && nshift < 12; i++) step();
    repeat (20) step();
    check("img_loads",       nload, 4);
    check("img_shifts",      nshift, 12);
    check("img_preload_cnt", loads_before_shift, 2);
    check("img_valids",      vcount, 12);
    check("img_fins",        fincount, 1);
    check("fin_tag",         fin_row * 4 + fin_ch * 2 + fin_w, 2 * 4 + 1 * 2 + 1);
    check("valid_latency",   first_v - first_shift, 3);
    check("done_busy",       int'(busy), 0);
    check("done_cmd",        int'(input_interface_cmd), 0);
    disable_run();
    check("idle_tag_hold",   int'({feature_row, feature_channel, feature_idx}), 5'b10_1_1);

    // Continuous: preload restarts, tags restart at zero
    clear_stats();
    continuous = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 300 && nshift < 12; i++) step();
    for (int i = 0; i < 30 && (nload + nshift) < 17; i++) step();
    check("restart_load", nload, 5);
    for (int i = 0; i < 30 && vcount < 13; i++) step();
    check("cont_valids", vcount, 13);
    check("restart_tag", int'({feature_row, feature_channel, feature_idx}), 0);
    disable_run();
    continuous = 1'b0;

    // Stall while the first shift is due
    clear_stats();
    enable = 1'b1;
    for (int i = 0; i < 40 && nload < 2; i++) step();
    stall = 1'b1;
    repeat (5) step();
    check("stall_hold",  nshift, 0);
    check("stall_busy",  int'(busy), 1);
    stall = 1'b0;
    step();
    check("stall_release", int'(input_interface_cmd), 2);
    check("stall_loads",   nload, 2);
    disable_run();

    // Mismatched ack in PRELOAD is ignored
    clear_stats();
    auto_ack = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 20 && nload < 1; i++) step();
    input_interface_ack = 2'd2;
    step();
    input_interface_ack = 2'd0;
    repeat (2) step();
    check("bogus_no_valid", vcount, 0);
    check("bogus_no_cmd",   nload + nshift, 1);
    input_interface_ack = 2'd1;
    step();
    input_interface_ack = 2'd0;
    for (int i = 0; i < 10 && (nload + nshift) < 2; i++) step();
    check("preload_hold", nload, 2);
    check("preload_noshift", nshift, 0);
    disable_run();
    auto_ack = 1'b1;

    // Enable dropped mid row 1, then re-enabled
    clear_stats();
    enable = 1'b1;
    for (int i = 0; i < 200 && vcount < 5; i++) step();
    check("row1_reached", ex_row, 1);
    disable_run();
    check("dis_busy",  int'(busy), 0);
    check("dis_cmd",   int'(input_interface_cmd), 0);
    check("dis_valid", int'(valid), 0);
    saved = vcount;
    repeat (5) step();
    check("dis_no_valid", vcount, saved);
    clear_stats();
    enable = 1'b1;
    for (int i = 0; i < 60 && vcount < 1; i++) step();
    check("reen_preload", loads_before_shift, 2);
    check("reen_row",     int'(feature_row), 0);

    // Reset while a shift is outstanding
    for (int i = 0; i < 60 && nshift < 3; i++) step();
    rst_n = 1'b0;
    pending = 2'd0;
    input_interface_ack = 2'd0;
    step();
    check("mrst_cmd",   int'(input_interface_cmd), 0);
    check("mrst_busy",  int'(busy), 0);
    check("mrst_valid", int'(valid), 0);
    check("mrst_tags",  int'({feature_row, feature_channel, feature_idx}), 0);
    check("mrst_fin",   int'(image_calc_fin), 0);
    clear_stats();
    rst_n = 1'b1;
    for (int i = 0; i < 60 && nshift < 1; i++) step();
    check("mrst_preload", loads_before_shift, 2);
    check("mrst_resume_busy", int'(busy), 1);
    disable_run();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
